// File: rtl/bp_pkg.sv
// Shared encodings and geometry helpers for the branch predictor.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tag_w(input int xlen, input int entries);
        return xlen - $clog2(entries) - 2;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state function, shared by the BTB and the PHT.
module bp_sat_counter
    import bp_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        if (i_taken) begin
            if (i_cnt != ST)
                o_cnt = i_cnt + 2'd1;
        end else begin
            if (i_cnt != SNT)
                o_cnt = i_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/bp_btb_2bit.sv
// Direct-mapped BTB with 2-bit counters, flush and saturating statistics.
// Define BP_GSHARE_EN to predict direction from a gshare-indexed PHT instead of the BTB counter.
module bp_btb_2bit
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32,
    parameter int CNT_W   = 16,
    parameter int HIST_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   rd_pc,
    output logic              rd_pred,
    output logic [XLEN-1:0]   rd_pred_pc,
    output logic [HIST_W-1:0] rd_hist,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_mispred,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              flush,
    output logic [CNT_W-1:0]  stat_lookups,
    output logic [CNT_W-1:0]  stat_mispred
);

    localparam int IDX_W = idx_w(ENTRIES);
    localparam int TAG_W = tag_w(XLEN, ENTRIES);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [1:0]       cnt;
    } btb_entry_t;

    btb_entry_t       r_btb [ENTRIES];
    logic [CNT_W-1:0] r_lookups;
    logic [CNT_W-1:0] r_mispred;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_pred;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;
    logic             w_alloc;
    logic [1:0]       w_btb_cnt_nxt;

    assign w_idx   = rd_pc[IDX_W+1:2];
    assign w_tag   = rd_pc[XLEN-1:IDX_W+2];
    assign w_hit   = r_btb[w_idx].valid && (r_btb[w_idx].tag == w_tag);

    assign w_uidx  = upd_pc[IDX_W+1:2];
    assign w_utag  = upd_pc[XLEN-1:IDX_W+2];
    assign w_uhit  = r_btb[w_uidx].valid && (r_btb[w_uidx].tag == w_utag);
    // A flush in the same cycle suppresses allocation so nothing survives it.
    assign w_alloc = upd_valid && !w_uhit && upd_taken && !flush;

    bp_sat_counter u_btb_cnt (
        .i_cnt   (r_btb[w_uidx].cnt),
        .i_taken (upd_taken),
        .o_cnt   (w_btb_cnt_nxt)
    );

`ifdef BP_GSHARE_EN
    logic [1:0]        r_pht [ENTRIES];
    logic [HIST_W-1:0] r_ghr;
    logic [IDX_W-1:0]  w_ghr_ext;
    logic [IDX_W-1:0]  w_uhist_ext;
    logic [IDX_W-1:0]  w_pidx;
    logic [IDX_W-1:0]  w_upidx;
    logic [1:0]        w_pht_cnt_nxt;
    logic              w_unused;

    always_comb begin
        w_ghr_ext                = '0;
        w_ghr_ext[HIST_W-1:0]    = r_ghr;
        w_uhist_ext              = '0;
        w_uhist_ext[HIST_W-1:0]  = upd_hist;
    end

    assign w_pidx   = w_idx ^ w_ghr_ext;
    assign w_upidx  = w_uidx ^ w_uhist_ext;
    assign w_pred   = w_hit && r_pht[w_pidx][1];
    assign rd_hist  = r_ghr;
    assign w_unused = ^upd_pc[1:0];

    bp_sat_counter u_pht_cnt (
        .i_cnt   (r_pht[w_upidx]),
        .i_taken (upd_taken),
        .o_cnt   (w_pht_cnt_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
            for (int i = 0; i < ENTRIES; i++)
                r_pht[i] <= WNT;
        end else if (upd_valid) begin
            r_ghr <= {r_ghr[HIST_W-2:0], upd_taken};
            if (w_uhit)
                r_pht[w_upidx] <= w_pht_cnt_nxt;
            else if (w_alloc)
                r_pht[w_upidx] <= WT;
        end
    end
`else
    logic w_unused;

    assign w_pred   = w_hit && r_btb[w_idx].cnt[1];
    assign rd_hist  = '0;
    assign w_unused = ^{upd_hist, upd_pc[1:0]};
`endif

    assign rd_pred    = w_pred;
    assign rd_pred_pc = w_pred ? r_btb[w_idx].target : rd_pc + XLEN'(4);

    // Tag and target carry no reset value; valid gates them after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
                r_btb[i].cnt   <= WNT;
            end
        end else begin
            if (upd_valid && w_uhit) begin
                r_btb[w_uidx].cnt <= w_btb_cnt_nxt;
                if (upd_taken)
                    r_btb[w_uidx].target <= upd_target;
            end else if (w_alloc) begin
                r_btb[w_uidx].valid  <= 1'b1;
                r_btb[w_uidx].tag    <= w_utag;
                r_btb[w_uidx].target <= upd_target;
                r_btb[w_uidx].cnt    <= WT;
            end
            if (flush) begin
                for (int i = 0; i < ENTRIES; i++)
                    r_btb[i].valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lookups <= '0;
            r_mispred <= '0;
        end else if (upd_valid) begin
            if (r_lookups != {CNT_W{1'b1}})
                r_lookups <= r_lookups + CNT_W'(1);
            if (upd_mispred && (r_mispred != {CNT_W{1'b1}}))
                r_mispred <= r_mispred + CNT_W'(1);
        end
    end

    assign stat_lookups = r_lookups;
    assign stat_mispred = r_mispred;

endmodule

// File: tb/tb_bp_btb_2bit.sv
// Directed bench for bp_btb_2bit (ENTRIES=64, CNT_W=4); gshare scenario built only with BP_GSHARE_EN.
module tb_bp_btb_2bit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] rd_pc;
    logic        rd_pred;
    logic [31:0] rd_pred_pc;
    logic [5:0]  rd_hist;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;
    logic [5:0]  upd_hist;
    logic        flush;
    logic [3:0]  stat_lookups;
    logic [3:0]  stat_mispred;

    int checks = 0;
    int errors = 0;

    bp_btb_2bit #(.ENTRIES(64), .XLEN(32), .CNT_W(4), .HIST_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_pc        (rd_pc),
        .rd_pred      (rd_pred),
        .rd_pred_pc   (rd_pred_pc),
        .rd_hist      (rd_hist),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .upd_mispred  (upd_mispred),
        .upd_hist     (upd_hist),
        .flush        (flush),
        .stat_lookups (stat_lookups),
        .stat_mispred (stat_mispred)
    );

    always #5 clk = ~clk;

    task automatic do_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic mp, input logic fl);
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_mispred = mp; flush = fl;
        @(posedge clk);
        #1;
        upd_valid = 1'b0; upd_mispred = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rd_pc = 32'h3000; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        upd_mispred = 0; upd_hist = 0; flush = 0;
        rst = 1'b1;
        #1;
        checks++; if (rd_pred !== 1'b0) begin errors++; $display("FAIL reset_pred got %0b want 0", rd_pred); end
        checks++; if (rd_pred_pc !== 32'h3004) begin errors++; $display("FAIL reset_pred_pc got %h want 00003004", rd_pred_pc); end
        checks++; if (rd_hist !== 6'd0) begin errors++; $display("FAIL reset_hist got %h want 0", rd_hist); end
        checks++; if (stat_lookups !== 4'd0) begin errors++; $display("FAIL reset_lookups got %0d want 0", stat_lookups); end
        checks++; if (stat_mispred !== 4'd0) begin errors++; $display("FAIL reset_mispred got %0d want 0", stat_mispred); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alloc();
        @(negedge clk);
        upd_valid = 1; upd_pc = 32'h3010; upd_taken = 1; upd_target = 32'h3040; upd_mispred = 1;
        rd_pc = 32'h3010;
        #1;
        checks++; if (rd_pred !== 1'b0 || rd_pred_pc !== 32'h3014) begin errors++;
            $display("FAIL same_cycle_no_bypass got %0b/%h want 0/00003014", rd_pred, rd_pred_pc); end
        @(posedge clk);
        #1;
        upd_valid = 0; upd_mispred = 0;
        checks++; if (rd_pred !== 1'b1 || rd_pred_pc !== 32'h3040) begin errors++;
            $display("FAIL alloc_hit got %0b/%h want 1/00003040", rd_pred, rd_pred_pc); end
        checks++; if (stat_lookups !== 4'd1 || stat_mispred !== 4'd1) begin errors++;
            $display("FAIL alloc_stats got %0d/%0d want 1/1", stat_lookups, stat_mispred); end
    endtask

    task automatic test_counter();
        logic tk [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic ep [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] exp_pc;
        for (int i = 0; i < 8; i++) begin
            do_upd(32'h3010, tk[i], 32'h3080, 1'b0, 1'b0);
            rd_pc = 32'h3010;
            #1;
            exp_pc = ep[i] ? 32'h3080 : 32'h3014;
            checks++; if (rd_pred !== ep[i] || rd_pred_pc !== exp_pc) begin errors++;
                $display("FAIL counter_step%0d got %0b/%h want %0b/%h", i, rd_pred, rd_pred_pc, ep[i], exp_pc); end
        end
        do_upd(32'h5000, 1'b0, 32'h5100, 1'b0, 1'b0);
        rd_pc = 32'h5000;
        #1;
        checks++; if (rd_pred !== 1'b0 || rd_pred_pc !== 32'h5004) begin errors++;
            $display("FAIL miss_not_taken got %0b/%h want 0/00005004", rd_pred, rd_pred_pc); end
    endtask

    task automatic test_alias();
        do_upd(32'h3110, 1'b1, 32'h3200, 1'b0, 1'b0);
        rd_pc = 32'h3110;
        #1;
        checks++; if (rd_pred !== 1'b1 || rd_pred_pc !== 32'h3200) begin errors++;
            $display("FAIL alias_new got %0b/%h want 1/00003200", rd_pred, rd_pred_pc); end
        rd_pc = 32'h3010;
        #1;
        checks++; if (rd_pred !== 1'b0 || rd_pred_pc !== 32'h3014) begin errors++;
            $display("FAIL alias_evicted got %0b/%h want 0/00003014", rd_pred, rd_pred_pc); end
        do_upd(32'h3010, 1'b0, 32'h3300, 1'b0, 1'b0);
        rd_pc = 32'h3110;
        #1;
        checks++; if (rd_pred !== 1'b1 || rd_pred_pc !== 32'h3200) begin errors++;
            $display("FAIL alias_nt_miss_keeps got %0b/%h want 1/00003200", rd_pred, rd_pred_pc); end
    endtask

    task automatic test_flush();
        do_reset();
        do_upd(32'h3010, 1'b1, 32'h3040, 1'b0, 1'b1);
        rd_pc = 32'h3010;
        #1;
        checks++; if (rd_pred !== 1'b0 || rd_pred_pc !== 32'h3014) begin errors++;
            $display("FAIL flush_wins got %0b/%h want 0/00003014", rd_pred, rd_pred_pc); end
        checks++; if (stat_lookups !== 4'd1) begin errors++;
            $display("FAIL flush_stat_lookups got %0d want 1", stat_lookups); end
        do_upd(32'h3020, 1'b1, 32'h3100, 1'b0, 1'b0);
        rd_pc = 32'h3020;
        #1;
        checks++; if (rd_pred !== 1'b1 || rd_pred_pc !== 32'h3100) begin errors++;
            $display("FAIL pre_flush_hit got %0b/%h want 1/00003100", rd_pred, rd_pred_pc); end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (rd_pred !== 1'b0 || rd_pred_pc !== 32'h3024) begin errors++;
            $display("FAIL flush_clears got %0b/%h want 0/00003024", rd_pred, rd_pred_pc); end
        checks++; if (stat_lookups !== 4'd2 || stat_mispred !== 4'd0) begin errors++;
            $display("FAIL flush_keeps_stats got %0d/%0d want 2/0", stat_lookups, stat_mispred); end
    endtask

    task automatic test_stats_sat();
        do_reset();
        for (int i = 0; i < 3; i++) do_upd(32'h7000, 1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (stat_lookups !== 4'd3 || stat_mispred !== 4'd0) begin errors++;
            $display("FAIL stats_no_mispred got %0d/%0d want 3/0", stat_lookups, stat_mispred); end
        for (int i = 0; i < 12; i++) do_upd(32'h7000, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (stat_lookups !== 4'd15 || stat_mispred !== 4'd12) begin errors++;
            $display("FAIL stats_mid got %0d/%0d want 15/12", stat_lookups, stat_mispred); end
        for (int i = 0; i < 8; i++) do_upd(32'h7000, 1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (stat_lookups !== 4'hF || stat_mispred !== 4'hF) begin errors++;
            $display("FAIL stats_saturate got %0d/%0d want 15/15", stat_lookups, stat_mispred); end
    endtask

    task automatic test_async_reset();
        do_upd(32'h3010, 1'b1, 32'h3040, 1'b0, 1'b0);
        rd_pc = 32'h3010;
        #1;
        checks++; if (rd_pred !== 1'b1) begin errors++;
            $display("FAIL async_pre_hit got %0b want 1", rd_pred); end
        @(negedge clk);
        upd_valid = 1; upd_pc = 32'h3010; upd_taken = 1; upd_target = 32'h3040; upd_mispred = 1;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (rd_pred !== 1'b0 || rd_pred_pc !== 32'h3014 || stat_lookups !== 4'd0) begin errors++;
            $display("FAIL async_immediate got %0b/%h/%0d want 0/00003014/0", rd_pred, rd_pred_pc, stat_lookups); end
        @(posedge clk);
        #1;
        upd_valid = 0; upd_mispred = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (rd_pred !== 1'b0 || stat_lookups !== 4'd0 || stat_mispred !== 4'd0) begin errors++;
            $display("FAIL async_discard got %0b/%0d/%0d want 0/0/0", rd_pred, stat_lookups, stat_mispred); end
    endtask

`ifdef BP_GSHARE_EN
    task automatic test_gshare();
        logic        p;
        logic [5:0]  h;
        logic        tk;
        logic [3:0]  snap;
        do_reset();
        snap = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_pc = 32'h4000;
            #1;
            p = rd_pred; h = rd_hist; tk = (i % 2 == 0);
            upd_valid = 1; upd_pc = 32'h4000; upd_taken = tk; upd_target = 32'h4080;
            upd_mispred = (p != tk); upd_hist = h;
            @(posedge clk);
            #1;
            upd_valid = 0; upd_mispred = 0;
            if (i == 7) snap = stat_mispred;
        end
        checks++; if (snap !== 4'd4) begin errors++;
            $display("FAIL gshare_warmup got %0d want 4", snap); end
        checks++; if (stat_mispred !== snap) begin errors++;
            $display("FAIL gshare_steady got %0d want %0d", stat_mispred, snap); end
    endtask
`endif

    initial begin
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_flush();
        test_stats_sat();
        test_async_reset();
`ifdef BP_GSHARE_EN
        test_gshare();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
